// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_reg_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [ADDR_W-1:0] ID_ADDR = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    // Command byte as it arrives MSB first: R/W flag then address.
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchronizer for an asynchronous pad input plus rise/fall detection.
//  clk, rst_n : system clock, async active-low reset
//  d          : asynchronous input
//  q          : synchronized level (registered)
//  rise_c     : combinational 1-clk pulse on a synchronized 0->1 transition
//  fall_c     : combinational 1-clk pulse on a synchronized 1->0 transition
// The edge pulses are visible two clocks after the pad change, so logic that
// registers on them acts on the third clock.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic prev;

    // Two-stage synchronizer followed by a history register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
            prev <= q;
        end
    end

    assign rise_c = q & ~prev;
    assign fall_c = ~q & prev;

endmodule

// File: rtl/spi_reg_responder.sv
// Mode-0 SPI register-access responder with a small 8-bit register bank.
//  clk, rst_n : system clock, async active-low reset
//  ena        : design selected; low aborts any frame in progress
//  cs_n_i     : chip select (active low, asynchronous)
//  sck_i      : serial clock (asynchronous)
//  mosi_i     : serial data in (asynchronous)
//  miso_o     : serial read data out
//  miso_oe    : output enable for miso_o
//  ctrl_o     : live copy of register 0
//  wr_pulse   : 1-clk pulse on each committed write
//  frame_err  : sticky, set when a frame is cut short
// Frame: bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = write data.
module spi_reg_responder
    import spi_reg_pkg::*;
#(
    parameter int unsigned NREGS  = 4,
    parameter logic [7:0]  ID_VAL = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cs_n_i,
    input  logic       sck_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe,
    output logic [7:0] ctrl_o,
    output logic       wr_pulse,
    output logic       frame_err
);

    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    // Synchronized pad inputs
    logic cs_n_sync;
    logic sck_rise_c;
    logic sck_fall_c;
    logic mosi_sync;
    logic sck_sync_unused;
    logic cs_unused_rise;
    logic cs_unused_fall;
    logic mosi_unused_rise;
    logic mosi_unused_fall;

    sync_edge_det #(.RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (cs_n_i),
        .q      (cs_n_sync),
        .rise_c (cs_unused_rise),
        .fall_c (cs_unused_fall)
    );

    sync_edge_det #(.RST_VAL(1'b0)) u_sck_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (sck_i),
        .q      (sck_sync_unused),
        .rise_c (sck_rise_c),
        .fall_c (sck_fall_c)
    );

    sync_edge_det #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (mosi_i),
        .q      (mosi_sync),
        .rise_c (mosi_unused_rise),
        .fall_c (mosi_unused_fall)
    );

    // Frame state
    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [6:0]         shift_q;
    logic [6:0]         shadow_q;
    logic               rw_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [7:0]         regs_q [NREGS];

    // Decoded controls
    logic               cs_active_c;
    logic               abort_c;
    logic               shift_c;
    logic               cmd_done_c;
    logic               frame_done_c;
    logic               miso_shift_c;
    logic [7:0]         new_byte_c;
    cmd_t               cmd_c;
    logic               cmd_hit_c;
    logic               wr_hit_c;
    logic [7:0]         read_val_c;

    assign cs_active_c = ~cs_n_sync & ena;

    // Byte completed by the current sck rise (last seven bits plus this one)
    assign new_byte_c = {shift_q, mosi_sync};
    assign cmd_c      = cmd_t'(new_byte_c);
    assign cmd_hit_c  = (32'(cmd_c.addr) < NREGS);
    assign wr_hit_c   = (32'(addr_q) < NREGS);

    // Read lookup for the address arriving with the command byte
    always_comb begin
        read_val_c = 8'h00;
        if (cmd_c.addr == ID_ADDR) begin
            read_val_c = ID_VAL;
        end else if (cmd_hit_c) begin
            read_val_c = regs_q[IDX_W'(cmd_c.addr)];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d      = state_q;
        abort_c      = 1'b0;
        shift_c      = 1'b0;
        cmd_done_c   = 1'b0;
        frame_done_c = 1'b0;
        miso_shift_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_active_c) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (!cs_active_c) begin
                    state_d = IDLE;
                    abort_c = 1'b1;
                end else if (sck_rise_c) begin
                    shift_c = 1'b1;
                    if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                        cmd_done_c = 1'b1;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                // Abort is checked first so it also beats a coincident 16th rise
                if (!cs_active_c) begin
                    state_d = IDLE;
                    abort_c = 1'b1;
                end else if (sck_rise_c) begin
                    shift_c = 1'b1;
                    if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        frame_done_c = 1'b1;
                        state_d      = DONE;
                    end
                end else if (sck_fall_c && (bit_cnt_q > CNT_W'(CMD_BITS))) begin
                    // The fall closing the last command bit keeps the MSB on
                    // the line; only later falls advance to the next bit.
                    miso_shift_c = 1'b1;
                end
            end
            DONE: begin
                if (!cs_active_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath, register bank and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            shadow_q  <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            miso_o    <= 1'b0;
            miso_oe   <= 1'b0;
            wr_pulse  <= 1'b0;
            frame_err <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[IDX_W'(i)] <= 8'h00;
            end
        end else begin
            wr_pulse <= 1'b0;

            if ((state_q == IDLE) || abort_c) begin
                bit_cnt_q <= '0;
            end else if (shift_c) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end

            if (shift_c) begin
                shift_q <= new_byte_c[6:0];
            end

            if (cmd_done_c) begin
                rw_q   <= cmd_c.rw;
                addr_q <= cmd_c.addr;
                if (cmd_c.rw) begin
                    miso_o   <= read_val_c[7];
                    shadow_q <= read_val_c[6:0];
                    miso_oe  <= 1'b1;
                end
            end

            if (miso_shift_c) begin
                miso_o   <= shadow_q[6];
                shadow_q <= {shadow_q[5:0], 1'b0};
            end

            if (frame_done_c || abort_c) begin
                miso_o  <= 1'b0;
                miso_oe <= 1'b0;
            end

            // Commit; out-of-range addresses (including the ID) are dropped
            if (frame_done_c && !rw_q && wr_hit_c) begin
                regs_q[IDX_W'(addr_q)] <= new_byte_c;
                wr_pulse               <= 1'b1;
            end

            if (abort_c) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign ctrl_o = regs_q[0];

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: directed frames plus random
// register traffic checked against a register-array model of the bank.
module tb_spi_reg_responder;

    localparam int unsigned NREGS = 4;
    localparam int          HALF  = 5;   // sck half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cs_n;
    logic       sck;
    logic       mosi;
    logic       miso_o;
    logic       miso_oe;
    logic [7:0] ctrl_o;
    logic       wr_pulse;
    logic       frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;

    logic [7:0] model_regs [NREGS];

    always #5 clk = ~clk;

    spi_reg_responder #(.NREGS(NREGS), .ID_VAL(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cs_n_i    (cs_n),
        .sck_i     (sck),
        .mosi_i    (mosi),
        .miso_o    (miso_o),
        .miso_oe   (miso_oe),
        .ctrl_o    (ctrl_o),
        .wr_pulse  (wr_pulse),
        .frame_err (frame_err)
    );

    // Count clocks with wr_pulse high (one per committed write)
    always @(negedge clk) begin
        if (wr_pulse === 1'b1) wr_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (a == 7'h7F) return 8'hA5;
        if (32'(a) < NREGS) return model_regs[a[1:0]];
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NREGS); i++) model_regs[i] = 8'h00;
    endtask

    // Host-side frame: npulses sck pulses, optional ena drop before pulse
    // drop_ena_at, optional cs_n release together with the last rise.
    // Returns the byte seen on miso at rises 9..16 and a count of pulses
    // where miso_oe was not what the host expects.
    task automatic spi_frame(input logic [15:0] f, input int npulses,
                             input int drop_ena_at, input bit cs_with_last,
                             output logic [7:0] rd, output int oe_bad);
        logic exp_oe;
        rd     = 8'h00;
        oe_bad = 0;
        cs_n   = 1'b0;
        tick(HALF);
        for (int i = 0; i < npulses; i++) begin
            if (i == drop_ena_at) ena = 1'b0;
            mosi = (i < 16) ? f[15 - i] : 1'($urandom);
            tick(HALF);
            if (cs_with_last && (i == npulses - 1)) cs_n = 1'b1;
            sck = 1'b1;
            if (i >= 8 && i < 16) rd[15 - i] = miso_o;
            exp_oe = (i >= 8) && (i < 16) && f[15] && ena;
            if (miso_oe !== exp_oe) oe_bad++;
            tick(HALF);
            sck = 1'b0;
        end
        tick(HALF);
        cs_n = 1'b1;
        tick(2 * HALF);
        ena = 1'b1;
        tick(2);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] rd;
        int         oe_bad;
        spi_frame({1'b0, a, d}, 16, -1, 1'b0, rd, oe_bad);
        if (32'(a) < NREGS) model_regs[a[1:0]] = d;
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a);
        logic [7:0] rd;
        int         oe_bad;
        spi_frame({1'b1, a, 8'h00}, 16, -1, 1'b0, rd, oe_bad);
        check(tag, 32'(rd), 32'(model_read(a)));
        check({tag, "_oe"}, 32'(oe_bad), 32'd0);
    endtask

    initial begin
        int         w0;
        logic [7:0] rd;
        int         oe_bad;
        logic [6:0] a;
        logic [7:0] d;
        logic [15:0] f;

        rst_n = 1'b0;
        ena   = 1'b1;
        cs_n  = 1'b1;
        sck   = 1'b0;
        mosi  = 1'b0;
        model_reset();
        tick(5);
        rst_n = 1'b1;
        tick(5);

        check("rst_ctrl",  32'(ctrl_o),    32'h00);
        check("rst_miso",  32'(miso_o),    32'h0);
        check("rst_oe",    32'(miso_oe),   32'h0);
        check("rst_wrp",   32'(wr_pulse),  32'h0);
        check("rst_err",   32'(frame_err), 32'h0);

        // Write reg 0
        w0 = wr_cnt;
        wr(7'h00, 8'h3C);
        check("w0_ctrl",  32'(ctrl_o),      32'h3C);
        check("w0_pulse", 32'(wr_cnt - w0), 32'd1);
        check("w0_err",   32'(frame_err),   32'h0);

        // Write then read back reg 2
        wr(7'h02, 8'h5A);
        rd_chk("rd_reg2", 7'h02);

        // ID and unmapped reads, dropped write
        rd_chk("rd_id", 7'h7F);
        rd_chk("rd_unmapped", 7'h10);
        w0 = wr_cnt;
        wr(7'h10, 8'h99);
        wr(7'h7F, 8'h11);
        check("wr_oor_pulse", 32'(wr_cnt - w0), 32'd0);
        check("wr_oor_err",   32'(frame_err),   32'h0);
        check("wr_oor_ctrl",  32'(ctrl_o),      32'h3C);
        rd_chk("rd_reg2_keep", 7'h02);
        rd_chk("rd_id_keep", 7'h7F);

        // Abort after 11 bits of a write to reg 1
        w0 = wr_cnt;
        spi_frame({1'b0, 7'h01, 8'hAB}, 11, -1, 1'b0, rd, oe_bad);
        check("abort_err",   32'(frame_err),   32'h1);
        check("abort_pulse", 32'(wr_cnt - w0), 32'd0);
        rd_chk("abort_reg1", 7'h01);
        w0 = wr_cnt;
        wr(7'h01, 8'h77);
        check("after_abort_pulse", 32'(wr_cnt - w0), 32'd1);
        rd_chk("after_abort_reg1", 7'h01);

        // 20 sck pulses in one write frame
        w0 = wr_cnt;
        spi_frame({1'b0, 7'h03, 8'h81}, 20, -1, 1'b0, rd, oe_bad);
        model_regs[3] = 8'h81;
        check("long_pulse", 32'(wr_cnt - w0), 32'd1);
        rd_chk("long_reg3", 7'h03);

        // cs_n rises together with the 16th sck rise: abort wins
        w0 = wr_cnt;
        spi_frame({1'b0, 7'h03, 8'h11}, 16, -1, 1'b1, rd, oe_bad);
        check("race_pulse", 32'(wr_cnt - w0), 32'd0);
        check("race_err",   32'(frame_err),   32'h1);
        rd_chk("race_reg3", 7'h03);

        // Random traffic against the model
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 5))
                0, 1, 2, 3: a = 7'($urandom_range(0, NREGS - 1));
                4:          a = 7'h7F;
                default:    a = 7'($urandom_range(NREGS, 126));
            endcase
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rd_chk("rand_rd", a);
            end else begin
                w0 = wr_cnt;
                wr(a, d);
                check("rand_wr_pulse", 32'(wr_cnt - w0), (32'(a) < NREGS) ? 32'd1 : 32'd0);
            end
        end
        check("rand_ctrl", 32'(ctrl_o), 32'(model_regs[0]));

        // Reset in the data phase of a read
        f = {1'b1, 7'h02, 8'h00};
        cs_n = 1'b0;
        tick(HALF);
        for (int i = 0; i < 12; i++) begin
            mosi = f[15 - i];
            tick(HALF);
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
        tick(2);
        check("pre_rst_oe", 32'(miso_oe), 32'h1);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_ctrl", 32'(ctrl_o),    32'h00);
        check("mid_rst_miso", 32'(miso_o),    32'h0);
        check("mid_rst_oe",   32'(miso_oe),   32'h0);
        check("mid_rst_wrp",  32'(wr_pulse),  32'h0);
        check("mid_rst_err",  32'(frame_err), 32'h0);
        cs_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        model_reset();
        tick(3);
        rd_chk("post_rst_reg2", 7'h02);

        // ena drops during a write to reg 0
        w0 = wr_cnt;
        spi_frame({1'b0, 7'h00, 8'hEE}, 16, 3, 1'b0, rd, oe_bad);
        check("ena_err",   32'(frame_err),   32'h1);
        check("ena_pulse", 32'(wr_cnt - w0), 32'd0);
        check("ena_ctrl",  32'(ctrl_o),      32'h00);
        check("ena_oe",    32'(miso_oe),     32'h0);

        // Error stays sticky across a good write
        wr(7'h00, 8'h12);
        check("sticky_err",  32'(frame_err), 32'h1);
        check("sticky_ctrl", 32'(ctrl_o),    32'h12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
